regfile_dump_load: RTL
======================

// Module: regfile_dump_load
// PURPOSE
//  Bulk access initiator for the 16x16 register file: it drives the register file's read and write ports.
//  A DUMP command reads a contiguous run of registers and emits them on a valid/ready output stream.
//  A LOAD command takes words from a valid/ready input stream and writes them into consecutive registers.
//  Sits between the debug/boot controller and the register file, muxed onto the rf ports while busy.
// PARAMETERS
//  DATA_W    16  register width in bits
//  ADDR_W    4   register address width in bits
//  NUM_REGS  16  register count; must equal 2**ADDR_W, so addresses wrap modulo NUM_REGS
// PORTS
//  clk          in   1         clock, rising edge
//  rst          in   1         asynchronous reset, active high
//  cmd_valid    in   1         command request
//  cmd_ready    out  1         command accepted when cmd_valid&&cmd_ready
//  cmd_op       in   1         0 = DUMP, 1 = LOAD
//  cmd_first    in   ADDR_W    first register address
//  cmd_count    in   ADDR_W+1  number of registers (0..NUM_REGS)
//  rf_rd_addr   out  ADDR_W    to rf read port; read data returns combinationally
//  rf_rd_data   in   DATA_W    rf read data
//  rf_wr_en     out  1         rf write enable
//  rf_wr_addr   out  ADDR_W    rf write address
//  rf_wr_data   out  DATA_W    rf write data
//  dout_valid   out  1         dump word valid
//  dout_ready   in   1         dump sink ready
//  dout_data    out  DATA_W    dump word (registered)
//  dout_last    out  1         high with the final dump word
//  din_valid    in   1         load word valid
//  din_ready    out  1         load word accepted when din_valid&&din_ready
//  din_data     in   DATA_W    load word
//  busy         out  1         high in every state except IDLE
//  done         out  1         one-cycle pulse when a command completes
// BEHAVIOUR
//  Reset: state=IDLE; cur_addr=0; remaining=0; dout_data=0.
//   All outputs low except cmd_ready, which is high because the block is in IDLE.
//  States: IDLE, DUMP_RD, DUMP_TX, LOAD, DONE.
//  IDLE: cmd_ready=1. On accept: cur_addr<=cmd_first; remaining<=min(cmd_count,NUM_REGS).
//   If the count is 0, go to DONE with no rf access. Otherwise go to DUMP_RD or LOAD per cmd_op.
//  DUMP_RD: rf_rd_addr=cur_addr; dout_data<=rf_rd_data. Next state is DUMP_TX.
//  DUMP_TX: dout_valid=1; dout_last=(remaining==1). dout_data stays stable until the handshake.
//   On dout_ready: cur_addr++ (wrapping), remaining--. Go to DONE if remaining was 1, else to DUMP_RD.
//   Latency: the first dout_valid appears 2 cycles after cmd accept; throughput is 1 word per 2 cycles.
//  LOAD: din_ready=1. rf_wr_en=din_valid (combinational).
//   rf_wr_addr=cur_addr; rf_wr_data=din_data. The write commits on the same clk edge as the din handshake.
//   On handshake: cur_addr++ (wrapping), remaining--. Go to DONE if remaining was 1.
//  DONE: done=1 for exactly one cycle; cmd_ready=0; next state is IDLE.
//  Outside their states: rf_wr_en=0, dout_valid=0, din_ready=0. rf_rd_addr holds cur_addr at all times.
//  Address wrap: the address after NUM_REGS-1 is 0 (first=14, count=4 -> 14,15,0,1).
//  cmd_count>NUM_REGS is clamped to NUM_REGS; no register is accessed twice in one command.
//  Commands are not accepted while busy; cmd_valid is ignored outside IDLE.
//  Reset mid-command: asynchronous return to IDLE. The partial dump or load is abandoned.
//   Registers already written keep their new values. No done pulse is produced.
// CONFIGURATION
//  REGFILE_R0_PROTECT_EN defined: LOAD words addressed to register 0 are still accepted (din_ready=1).
//   For those words rf_wr_en stays 0, and cur_addr and remaining advance normally.
//  Undefined: register 0 is written like any other register.
// TESTING
//  1 Preload rf[i]=i*0x1111; DUMP first=0 count=16 with dout_ready=1.
//    -> 16 words 0x0000..0xFFFF; dout_last only on the 16th; done 1 cycle later.
//  2 DUMP first=3 count=2 with dout_ready low for 5 cycles.
//    -> dout_data=rf[3] held stable with dout_valid=1; then rf[4] with dout_last=1.
//  3 LOAD first=14 count=4, din=0xA001..0xA004.
//    -> rf[14]=0xA001, rf[15]=0xA002, rf[0]=0xA003, rf[1]=0xA004; done pulses once.
//  4 Command with count=0 -> done 1 cycle after accept, no rf_wr_en, no dout_valid.
//    Command with count=20 -> exactly 16 accesses.
//  5 Assert rst after 2 of 4 LOAD words -> only the first 2 rf writes occur.
//    Outputs go to reset values at once; no done; cmd_ready=1 after rst is released.
//  6 With REGFILE_R0_PROTECT_EN, LOAD first=15 count=2 din=0xBEEF,0xCAFE.
//    -> rf[15]=0xBEEF; rf[0] unchanged; both words accepted.

Source files
------------

// File: rtl/regfile_dump_load.sv
// regfile_dump_load
//   Bulk access initiator for a NUM_REGS x DATA_W register file. A DUMP
//   command reads a contiguous (wrapping) run of registers and streams them
//   out on a valid/ready port; a LOAD command writes words taken from a
//   valid/ready input stream into consecutive (wrapping) registers.
//
// Ports
//   clk, rst                      clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready           command handshake (accepted only in IDLE)
//   cmd_op                        0 = DUMP, 1 = LOAD
//   cmd_first, cmd_count          first address, register count (clamped to NUM_REGS)
//   rf_rd_addr, rf_rd_data        register file read port (combinational read)
//   rf_wr_en/addr/data            register file write port
//   dout_valid/ready/data/last    dump output stream (dout_data registered)
//   din_valid/ready/data          load input stream
//   busy                          high whenever not IDLE
//   done                          one-cycle pulse when a command completes
//
// Configuration
//   REGFILE_R0_PROTECT_EN  when defined, LOAD words addressed to register 0
//                          are accepted and counted but not written.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a command, cmd_ready high
// DUMP_RD | read rf at cur_addr into the dout_data register
// DUMP_TX | present dout_data on the stream, wait for dout_ready
// LOAD    | accept din words, write each to rf at cur_addr
// DONE    | one-cycle done pulse, then back to IDLE

module regfile_dump_load #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [ADDR_W-1:0] cmd_first,
    input  logic [ADDR_W:0]   cmd_count,
    output logic [ADDR_W-1:0] rf_rd_addr,
    input  logic [DATA_W-1:0] rf_rd_data,
    output logic              rf_wr_en,
    output logic [ADDR_W-1:0] rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [DATA_W-1:0] dout_data,
    output logic              dout_last,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic [DATA_W-1:0] din_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DUMP_RD = 3'd1,
        S_DUMP_TX = 3'd2,
        S_LOAD    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [ADDR_W:0]   NUM_REGS_C = (ADDR_W+1)'(NUM_REGS);
    localparam logic [ADDR_W:0]   REM_ONE    = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cur_addr, cur_addr_nxt;
    logic [ADDR_W:0]   remaining, remaining_nxt;
    logic [DATA_W-1:0] dout_q, dout_nxt;
    logic [ADDR_W:0]   count_clamped;
    logic              wr_blocked;

    assign count_clamped = (cmd_count > NUM_REGS_C) ? NUM_REGS_C : cmd_count;

`ifdef REGFILE_R0_PROTECT_EN
    assign wr_blocked = (cur_addr == '0);
`else
    assign wr_blocked = 1'b0;
`endif

    // NUM_REGS == 2**ADDR_W, so the natural ADDR_W-bit increment wraps correctly.
    assign rf_rd_addr = cur_addr;
    assign rf_wr_addr = cur_addr;
    assign dout_data  = dout_q;
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            dout_q    <= '0;
        end else begin
            state     <= state_nxt;
            cur_addr  <= cur_addr_nxt;
            remaining <= remaining_nxt;
            dout_q    <= dout_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cur_addr_nxt  = cur_addr;
        remaining_nxt = remaining;
        dout_nxt      = dout_q;
        cmd_ready     = 1'b0;
        dout_valid    = 1'b0;
        dout_last     = 1'b0;
        din_ready     = 1'b0;
        rf_wr_en      = 1'b0;
        rf_wr_data    = '0;
        done          = 1'b0;

        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    cur_addr_nxt  = cmd_first;
                    remaining_nxt = count_clamped;
                    if (count_clamped == '0)
                        state_nxt = S_DONE;
                    else if (cmd_op)
                        state_nxt = S_LOAD;
                    else
                        state_nxt = S_DUMP_RD;
                end
            end
            S_DUMP_RD: begin
                dout_nxt  = rf_rd_data;
                state_nxt = S_DUMP_TX;
            end
            S_DUMP_TX: begin
                dout_valid = 1'b1;
                dout_last  = (remaining == REM_ONE);
                if (dout_ready) begin
                    cur_addr_nxt  = cur_addr + ADDR_ONE;
                    remaining_nxt = remaining - REM_ONE;
                    state_nxt     = (remaining == REM_ONE) ? S_DONE : S_DUMP_RD;
                end
            end
            S_LOAD: begin
                din_ready  = 1'b1;
                rf_wr_en   = din_valid && !wr_blocked;
                rf_wr_data = din_data;
                if (din_valid) begin
                    cur_addr_nxt  = cur_addr + ADDR_ONE;
                    remaining_nxt = remaining - REM_ONE;
                    if (remaining == REM_ONE)
                        state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule
